// File: rtl/if_pcu.sv
// Instruction-fetch program counter unit: prioritised next-PC selection,
// fetch address legality check and a two-state RUN/FAULT machine.
module if_pcu #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TEXT_LO    = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] TEXT_HI    = WIDTH'(32'h0000_6ffc),
  parameter logic [WIDTH-1:0] HANDLER_PC = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc_flush,
  output logic [WIDTH-1:0] PC,
  output logic [4:0]       ExcCode,
  output logic             fetch_valid,
  output logic             redirected
);

  localparam logic [4:0]       EXC_NONE = 5'd0;
  localparam logic [4:0]       EXC_ADEL = 5'd4;
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(32'd4);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cand;
  logic             load;
  logic             redirect;
  logic             cand_fault;

  // The handler entry is trusted; anything else must be word aligned inside the text window.
  function automatic logic addr_fault(input logic [WIDTH-1:0] addr);
    if (addr == HANDLER_PC) begin
      return 1'b0;
    end else begin
      return (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
    end
  endfunction

  // Next-address selection: flush and eret bypass the stall and the FAULT state.
  always_comb begin
    cand     = PC + PC_STEP;
    load     = 1'b0;
    redirect = 1'b0;
    if (exc_flush) begin
      cand     = HANDLER_PC;
      load     = 1'b1;
      redirect = 1'b1;
    end else if (eret) begin
      cand     = epc;
      load     = 1'b1;
      redirect = 1'b1;
    end else if (en && (state == RUN)) begin
      load = 1'b1;
      if (br_taken) begin
        cand     = br_target;
        redirect = 1'b1;
      end else begin
        cand     = PC + PC_STEP;
        redirect = 1'b0;
      end
    end else begin
      load     = 1'b0;
      redirect = 1'b0;
    end
    cand_fault = addr_fault(cand);
  end

  // PC, exception code, state machine and status flags; a faulting address is kept in PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC          <= RESET_PC;
      ExcCode     <= EXC_NONE;
      state       <= RUN;
      fetch_valid <= 1'b1;
      redirected  <= 1'b0;
    end else if (load) begin
      PC          <= cand;
      ExcCode     <= cand_fault ? EXC_ADEL : EXC_NONE;
      state       <= cand_fault ? FAULT : RUN;
      fetch_valid <= ~cand_fault;
      redirected  <= redirect;
    end else begin
      redirected  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_pcu.sv
// Self-checking bench for if_pcu: directed scenarios plus randomized traffic
// compared against an address-rule reference model.
module tb_if_pcu;

  logic        clk;
  logic        reset;
  logic        en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        eret;
  logic [31:0] epc;
  logic        exc_flush;
  logic [31:0] PC;
  logic [4:0]  ExcCode;
  logic        fetch_valid;
  logic        redirected;

  logic        reset16;
  logic        en16;
  logic [15:0] PC16;
  logic [4:0]  ExcCode16;
  logic        fetch_valid16;
  logic        redirected16;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_run;
  logic [4:0]  m_exc;
  bit          m_redir;

  if_pcu dut (
    .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .br_target(br_target),
    .eret(eret), .epc(epc), .exc_flush(exc_flush), .PC(PC), .ExcCode(ExcCode),
    .fetch_valid(fetch_valid), .redirected(redirected)
  );

  if_pcu #(
    .WIDTH(16), .RESET_PC(16'hfffc), .TEXT_LO(16'h0000),
    .TEXT_HI(16'hfffc), .HANDLER_PC(16'h4180)
  ) dut16 (
    .clk(clk), .reset(reset16), .en(en16), .br_taken(1'b0), .br_target(16'h0000),
    .eret(1'b0), .epc(16'h0000), .exc_flush(1'b0), .PC(PC16), .ExcCode(ExcCode16),
    .fetch_valid(fetch_valid16), .redirected(redirected16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a == 32'h0000_4180) ||
           ((a % 4 == 0) && (a >= 32'h0000_3000) && (a <= 32'h0000_6ffc));
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_run = 1'b1; m_exc = 5'd0; m_redir = 1'b0;
  endtask

  // Apply the fetch rules to the inputs present at the coming edge.
  task automatic model_step();
    logic [31:0] target;
    bit          take;
    bit          nonseq;
    take = 1'b1; nonseq = 1'b1; target = 32'h0;
    if (exc_flush)            target = 32'h0000_4180;
    else if (eret)            target = epc;
    else if (en && m_run && br_taken) target = br_target;
    else if (en && m_run) begin
      target = 32'(64'(m_pc) + 64'd4);
      nonseq = 1'b0;
    end else begin
      take = 1'b0;
    end
    if (take) begin
      m_pc    = target;
      m_run   = is_legal(target);
      m_exc   = m_run ? 5'd0 : 5'd4;
      m_redir = nonseq;
    end else begin
      m_redir = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"},    64'(PC),          64'(m_pc));
    check({tag, ".exc"},   64'(ExcCode),     64'(m_exc));
    check({tag, ".valid"}, 64'(fetch_valid), 64'(m_run));
    check({tag, ".redir"}, 64'(redirected),  64'(m_redir));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_in(input bit e, input bit b, input logic [31:0] bt,
                        input bit r, input logic [31:0] ep, input bit f);
    en = e; br_taken = b; br_target = bt; eret = r; epc = ep; exc_flush = f;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0: a = 32'h0000_4180;
      1: a = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
      2: a = (32'h0000_3000 + ($urandom_range(0, 4095) << 2)) | 32'($urandom_range(1, 3));
      3: a = 32'($urandom_range(0, 32'h0000_2fff));
      4: a = ($urandom_range(0, 1) == 0) ? 32'h0000_7000 + ($urandom_range(0, 999) << 2)
                                         : 32'hffff_fffc;
      default: begin
        case ($urandom_range(0, 3))
          0: a = 32'h0000_2ffc;
          1: a = 32'h0000_3000;
          2: a = 32'h0000_6ffc;
          default: a = 32'h0000_7000;
        endcase
      end
    endcase
    return a;
  endfunction

  initial begin
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    en16 = 1'b0;
    reset = 1'b1; reset16 = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset16.pc", 64'(PC16), 64'h fffc);
    reset = 1'b0; reset16 = 1'b0;

    // sequential fetch
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) tick("seq");
    check("seq.pc_300c", 64'(PC), 64'h300c);

    // misaligned branch faults and then holds
    set_in(1'b1, 1'b1, 32'h0000_3002, 1'b0, 32'h0, 1'b0);
    tick("br_misalign");
    check("br_misalign.exc4", 64'(ExcCode), 64'd4);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("fault_hold1");
    br_taken = 1'b1; br_target = 32'h0000_3100;
    tick("fault_hold2");
    check("fault_hold.pc", 64'(PC), 64'h3002);

    // eret recovers from FAULT even while stalled
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3010, 1'b0);
    tick("eret_recover");
    check("eret_recover.pc", 64'(PC), 64'h3010);

    // sequential overrun past the top of the text window, then flush
    set_in(1'b1, 1'b1, 32'h0000_6ffc, 1'b0, 32'h0, 1'b0);
    tick("br_top");
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick("overrun");
    check("overrun.pc", 64'(PC), 64'h7000);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick("flush");
    check("flush.pc", 64'(PC), 64'h4180);

    // eret with an illegal epc stays in FAULT
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2ffc, 1'b0);
    tick("eret_bad");

    // all redirects at once: flush wins
    set_in(1'b0, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_6000, 1'b1);
    tick("prio_en0");
    set_in(1'b1, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_6000, 1'b1);
    tick("prio_en1");

    // enter FAULT, then reset between edges takes effect immediately
    set_in(1'b1, 1'b1, 32'h0000_3001, 1'b0, 32'h0, 1'b0);
    tick("pre_reset_fault");
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    #1 reset = 1'b0;
    tick("after_reset");

    // 16-bit instance wraps fffc -> 0000 legally
    en16 = 1'b1;
    @(posedge clk); #1;
    check("wrap16.pc", 64'(PC16), 64'h0000);
    check("wrap16.exc", 64'(ExcCode16), 64'd0);
    check("wrap16.valid", 64'(fetch_valid16), 64'd1);
    @(posedge clk); #1;
    check("wrap16.pc_next", 64'(PC16), 64'h0004);
    check("wrap16.redir", 64'(redirected16), 64'd0);
    en16 = 1'b0;
    model_step(); // dut also advanced on those two edges
    model_step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(),
             $urandom_range(0, 7) == 0, rand_addr(), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) begin
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rand_reset");
        #1 reset = 1'b0;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
